// File: rtl/uart_tx_axis.sv
// AXI4-Stream to UART transmitter: 8N1 framing, one byte per frame, no buffering.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_axis #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned BAUD_RATE      = 115_200
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      tx,
  output logic                      busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_axis: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  if (AXI_DATA_WIDTH < 8) begin : g_bad_width
    $error("uart_tx_axis: AXI_DATA_WIDTH must be at least 8");
  end else if (AXI_DATA_WIDTH > 8) begin : g_upper_unused
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata[AXI_DATA_WIDTH-1:8];
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             tready_q, tready_d;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_done ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    tready_d = tready_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        tx_d     = 1'b1;
        tready_d = 1'b1;
        // tready_q gates the handshake so the first edge after reset only raises tready.
        if (s_axis_tvalid && tready_q) begin
          state_d  = StStart;
          tx_d     = 1'b0;
          tready_d = 1'b0;
          shift_d  = s_axis_tdata[7:0];
          idx_d    = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^s_axis_tdata[7:0];
`endif
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = parity_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          state_d  = StIdle;
          tx_d     = 1'b1;
          tready_d = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        tx_d     = 1'b1;
        tready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      tready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      tready_q <= tready_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx            = tx_q;
  assign s_axis_tready = tready_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_axis.sv
// Self-checking bench for uart_tx_axis at 10 clocks per bit; follows UART_TX_PARITY_EN if defined.
module tb_uart_tx_axis;

  localparam int unsigned CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME = NBITS * CPB;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b1;
  logic [31:0] tdata   = 32'd0;
  logic        tvalid  = 1'b0;
  logic        tready;
  logic        tx;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  uart_tx_axis #(
    .AXI_DATA_WIDTH(32),
    .CLK_FREQ      (50_000_000),
    .BAUD_RATE     (5_000_000)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .tx           (tx),
    .busy         (busy)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns at a falling edge with tready high, or flags a timeout.
  task automatic wait_ready(input int unsigned max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < int'(max_cyc); i++) begin
      if (tready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    chk("tready_wait", 32'(seen), 32'd1);
  endtask

  // Call right after the handshake edge. Checks every line cycle of the frame, decodes the
  // data bits at mid-bit, then checks the idle cycle that follows.
  task automatic run_frame(input logic [7:0] b, input logic par, input bit noise,
                           input logic [7:0] nxt, input logic nxt_valid);
    logic       bits [NBITS];
    logic [7:0] dec;
    int         bi;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    bits[9]       = par;
    bits[NBITS-1] = 1'b1;
    dec = 8'd0;
    for (int k = 0; k < int'(FRAME); k++) begin
      @(negedge aclk);
      bi = k / int'(CPB);
      chk($sformatf("tx_linebit%0d_cyc%0d", bi, k % int'(CPB)), 32'(tx), 32'(bits[bi]));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("tready_in_frame", 32'(tready), 32'd0);
      if (bi >= 1 && bi <= 8 && (k % int'(CPB)) == int'(CPB / 2)) dec[bi-1] = tx;
      if (noise && k != int'(FRAME) - 1) begin
        tvalid = 1'($urandom);
        tdata  = $urandom;
      end else if (k == 0 || k == int'(FRAME) - 1) begin
        tvalid = nxt_valid;
        tdata  = {24'($urandom), nxt};
      end
    end
    @(negedge aclk);
    chk("tready_after_frame", 32'(tready), 32'd1);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("tx_after_frame", 32'(tx), 32'd1);
    chk("decoded_byte", 32'(dec), 32'(b));
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [23:0] upper;
    logic [7:0]  later;
    logic        par;
  } vec_t;

  vec_t        vecs [10];
  int unsigned c1, c2;
  logic [7:0]  rb;

  initial begin
    vecs[0] = '{data: 8'h55, upper: 24'hDEAD00, later: 8'h00, par: 1'b0};
    vecs[1] = '{data: 8'h12, upper: 24'h000000, later: 8'hFF, par: 1'b0};
    vecs[2] = '{data: 8'h07, upper: 24'hFFFFFF, later: 8'h00, par: 1'b1};
    vecs[3] = '{data: 8'h03, upper: 24'h123456, later: 8'hAA, par: 1'b0};
    vecs[4] = '{data: 8'h00, upper: 24'hFFFFFF, later: 8'hFF, par: 1'b0};
    vecs[5] = '{data: 8'hFF, upper: 24'h000000, later: 8'h00, par: 1'b0};
    vecs[6] = '{data: 8'h01, upper: 24'hA5A5A5, later: 8'hFE, par: 1'b1};
    vecs[7] = '{data: 8'h80, upper: 24'h5A5A5A, later: 8'h7F, par: 1'b1};
    vecs[8] = '{data: 8'hA3, upper: 24'h0F0F0F, later: 8'h5C, par: 1'b0};
    vecs[9] = '{data: 8'hE0, upper: 24'hF0F0F0, later: 8'h1F, par: 1'b1};

    // Asynchronous reset with no clock edge yet.
    #2 aresetn = 1'b0;
    #1;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tready", 32'(tready), 32'd0);
    repeat (3) @(negedge aclk);
    chk("reset_held_tready", 32'(tready), 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_first_edge", 32'(tready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Table of single frames; tdata changes right after each handshake.
    foreach (vecs[i]) begin
      tdata  = {vecs[i].upper, vecs[i].data};
      tvalid = 1'b1;
      wait_ready(50);
      @(posedge aclk);
      run_frame(vecs[i].data, vecs[i].par, 1'b0, vecs[i].later, 1'b0);
    end

    // Back-to-back handshakes under continuous tvalid.
    tdata  = 32'h0000_00A3;
    tvalid = 1'b1;
    wait_ready(50);
    c1 = cyc;
    @(posedge aclk);
    run_frame(8'hA3, 1'b0, 1'b0, 8'h0F, 1'b1);
    c2 = cyc;
    @(posedge aclk);
    run_frame(8'h0F, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("handshake_period", c2 - c1, FRAME + 1);

    // Reset during data bit 3 of 0xC4 aborts the frame.
    tdata  = 32'h0000_00C4;
    tvalid = 1'b1;
    wait_ready(50);
    @(posedge aclk);
    @(negedge aclk);
    tvalid = 1'b0;
    repeat (44) @(negedge aclk);
    chk("pre_abort_data_bit3", 32'(tx), 32'd0);
    aresetn = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tready", 32'(tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < int'(FRAME); i++) begin
      @(negedge aclk);
      chk("post_abort_tx", 32'(tx), 32'd1);
      chk("post_abort_busy", 32'(busy), 32'd0);
    end
    tdata  = 32'h0000_003C;
    tvalid = 1'b1;
    wait_ready(50);
    @(posedge aclk);
    run_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);

    // Random bytes with tvalid/tdata churning while the frame is on the line.
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge aclk);
      tdata  = {24'($urandom), rb};
      tvalid = 1'b1;
      wait_ready(50);
      @(posedge aclk);
      run_frame(rb, ^rb, 1'b1, 8'h00, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
